reaction_round_controller: RTL and testbench
============================================

# reaction_round_controller

Session sequencer for the reaction-timer datapath. Once the top-level state machine hands it control, it runs a fixed number of timed rounds. Each round waits a pseudo-random delay, lights the stimulus, then measures reaction time in milliseconds and detects false starts. Best and average results go back to the display/score states.

## Interface
- CLK_HZ, 50_000_000: clk frequency; ms tick divisor TICK_DIV = CLK_HZ/1000 (bench overrides to give TICK_DIV = 4).
- ROUNDS, 4: rounds per session; legal values 1, 2, 4, 8 (power of two).
- MIN_DELAY_MS, 1000: fixed part of the pre-stimulus delay.
- FAULT_MS, 500: hold time after a false start.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- start  in  1  begin session; sampled only in IDLE.
- react  in  1  player button, active-high, already synchronized and debounced; the controller acts on its rising edge.
- abort  in  1  abandon session; highest priority after reset.
- stimulus  out  1  reaction LED on.
- busy  out  1  high in every state except IDLE.
- round_idx  out  3  current round, 0..ROUNDS-1.
- rt_ms  out  10  last recorded reaction time, 0..999.
- rt_valid  out  1  one-cycle pulse when rt_ms updates.
- false_start  out  1  one-cycle pulse on a false start.
- best_ms  out  10  minimum rt_ms this session.
- avg_ms  out  10  sum/ROUNDS; valid once done has pulsed.
- done  out  1  one-cycle pulse at session end.
- state_code  out  3  encoded state (debug display).

## Operation
- States and codes: IDLE 0, ARM 1, DELAY 2, REACT 3, RECORD 4, FAULT 5, DONE 6. Codes 7+ are illegal and go to IDLE on the next cycle.
- IDLE, start=1 → ARM. On this transition: round_idx=0, sum=0, best_ms=999.
- ARM (1 cycle):
  - load delay counter = MIN_DELAY_MS + lfsr[10:0].
  - clear the prescaler → DELAY.
- DELAY:
  - decrement the delay counter on each ms tick.
  - reaches 0 → REACT: stimulus=1, ms counter=0, prescaler cleared.
  - react rising edge → FAULT with a false_start pulse. The round is not counted and round_idx is unchanged.
- REACT:
  - ms counter increments per tick and saturates at 999.
  - react rising edge → RECORD, latching rt_ms = counter value in that cycle (a tick in the same cycle is not counted).
- RECORD (1 cycle):
  - rt_valid pulse, stimulus=0, sum += rt_ms (13-bit), best_ms = min(best_ms, rt_ms).
  - round_idx == ROUNDS-1 → DONE; otherwise round_idx++ → ARM.
- FAULT: hold FAULT_MS ticks, stimulus=0 → ARM (same round, new delay).
- DONE (1 cycle):
  - avg_ms = sum >> log2(ROUNDS), truncated; done pulse → IDLE.
  - rt_ms, best_ms and avg_ms hold until the next accepted start.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1 at reset. It advances every clock in all states and never reaches zero.
- react edge detector: register react_q. It resets to 1, so a held button at reset or entry does not produce an edge.
- start while busy: ignored.
- react edge in IDLE, ARM, RECORD, FAULT, DONE: ignored.
- abort=1 in any state → IDLE next cycle.
  - stimulus=0; no done, rt_valid or false_start pulse.
  - rt_ms, best_ms and avg_ms keep their prior values.

## Timing
- Reset values: state IDLE, stimulus 0, busy 0, round_idx 0, rt_ms 0, best_ms 999, avg_ms 0, all pulses 0, state_code 0.
- Outputs are registered. stimulus rises in the cycle after the delay counter hits 0.
- Prescaler counts TICK_DIV-1 down to 0 and restarts. The first tick comes TICK_DIV cycles after a clear.
- Latency:
  - start → busy: 1 cycle.
  - react edge (REACT) → rt_valid: 2 cycles (REACT→RECORD, then pulse).
  - final RECORD → done: 1 cycle.
- Total DELAY duration is (MIN_DELAY_MS + lfsr[10:0]) × TICK_DIV cycles, ±1.

## Configuration
- REACT_TIMEOUT_EN defined: when the REACT counter reaches 999 with no react edge, the controller records rt_ms=999 and moves to RECORD automatically.
- REACT_TIMEOUT_EN undefined: REACT waits indefinitely; the counter holds at 999 and rt_ms=999 is latched when react finally rises.

## Test plan
- Reset, then idle 20 cycles → all outputs at reset values; state_code=0; stimulus=0.
- TICK_DIV=4, ROUNDS=2, MIN_DELAY_MS=2; start; react edge 10 ticks after each stimulus rise, then 30 ticks → rt_ms 10 then 30; best_ms=10; avg_ms=20; one done pulse.
- Start, then react edge during DELAY → false_start pulse, FAULT for FAULT_MS ticks, then ARM; round_idx unchanged; sum unaffected (final avg excludes it).
- abort in REACT with stimulus=1 → next cycle IDLE, stimulus=0, busy=0, no done; best_ms and avg_ms equal pre-session values.
- react held high across start and the stimulus rise → no false start and no record until react falls and rises again.
- Never press react; REACT_TIMEOUT_EN defined → rt_ms=999 after 999 ticks. Undefined → stays in REACT (state_code=3) for 2000+ ticks.

Source files
------------

// File: rtl/reaction_round_controller_if.sv
// reaction_round_controller_if
// Player/session signals of the reaction-round controller. The slave
// modport is the controller's view and the master modport is the driver's view.
// Names carry the controller's direction: i_ = into the controller, o_ = out of it.
interface reaction_round_controller_if;
    logic       i_start;
    logic       i_react;
    logic       i_abort;
    logic       o_stimulus;
    logic       o_busy;
    logic [2:0] o_round_idx;
    logic [9:0] o_rt_ms;
    logic       o_rt_valid;
    logic       o_false_start;
    logic [9:0] o_best_ms;
    logic [9:0] o_avg_ms;
    logic       o_done;
    logic [2:0] o_state_code;

    modport slave (
        input  i_start, i_react, i_abort,
        output o_stimulus, o_busy, o_round_idx, o_rt_ms, o_rt_valid,
               o_false_start, o_best_ms, o_avg_ms, o_done, o_state_code
    );

    modport master (
        output i_start, i_react, i_abort,
        input  o_stimulus, o_busy, o_round_idx, o_rt_ms, o_rt_valid,
               o_false_start, o_best_ms, o_avg_ms, o_done, o_state_code
    );
endinterface

// File: rtl/reaction_round_controller.sv
// reaction_round_controller
// Runs ROUNDS timed reaction rounds: pseudo-random pre-stimulus delay, stimulus,
// millisecond reaction measurement, false-start detection, best/average scoring.
// Optional feature macro: REACT_TIMEOUT_EN -- when defined, a round with no
// press is recorded as 999 ms as soon as the reaction counter saturates.
module reaction_round_controller #(
    parameter int CLK_HZ       = 50_000_000,
    parameter int ROUNDS       = 4,
    parameter int MIN_DELAY_MS = 1000,
    parameter int FAULT_MS     = 500
) (
    input  logic                        clk,
    input  logic                        reset,
    reaction_round_controller_if.slave  bus
);
    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LOG2_R   = $clog2(ROUNDS);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ARM    = 3'd1;
    localparam logic [2:0] S_DELAY  = 3'd2;
    localparam logic [2:0] S_REACT  = 3'd3;
    localparam logic [2:0] S_RECORD = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;

    localparam logic [9:0] MS_MAX = 10'd999;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic          w_presc_clr;
    logic [15:0]   r_delay;
    logic [9:0]    r_ms;
    logic [9:0]    r_rt_cap;
    logic          r_react_q;
    logic          w_react_edge;
    logic [15:0]   r_lfsr;
    logic          w_lfsr_fb;
    logic [12:0]   r_sum;
    logic [2:0]    r_round;
    logic          w_last_round;
    logic          w_timeout;
    logic [9:0]    r_best;
    logic [9:0]    r_avg;
    logic [9:0]    r_rt_ms;

    logic          w_stimulus_d;
    logic          w_busy_d;
    logic          w_rt_valid_d;
    logic          w_false_start_d;
    logic          w_done_d;
    logic          r_stimulus;
    logic          r_busy;
    logic          r_rt_valid;
    logic          r_false_start;
    logic          r_done;

    assign w_tick       = (r_presc == {PW{1'b0}});
    assign w_react_edge = bus.i_react & ~r_react_q;
    assign w_last_round = (r_round == 3'(ROUNDS - 1));
    assign w_lfsr_fb    = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

`ifdef REACT_TIMEOUT_EN
    assign w_timeout = (r_ms == MS_MAX);
`else
    assign w_timeout = 1'b0;
`endif

    // The prescaler restarts whenever a timed phase (DELAY, REACT, FAULT) is entered.
    assign w_presc_clr = (w_next != r_state) &&
                         ((w_next == S_DELAY) || (w_next == S_REACT) || (w_next == S_FAULT));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; abort overrides every state.
    always_comb begin
        w_next = r_state;
        if (bus.i_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (bus.i_start) w_next = S_ARM; else w_next = S_IDLE;
                S_ARM:    w_next = S_DELAY;
                S_DELAY: begin
                    if (w_react_edge)              w_next = S_FAULT;
                    else if (r_delay == 16'd0)     w_next = S_REACT;
                    else                           w_next = S_DELAY;
                end
                S_REACT:  if (w_react_edge || w_timeout) w_next = S_RECORD; else w_next = S_REACT;
                S_RECORD: if (w_last_round) w_next = S_DONE; else w_next = S_ARM;
                S_FAULT:  if (r_delay == 16'd0) w_next = S_ARM; else w_next = S_FAULT;
                S_DONE:   w_next = S_IDLE;
                default:  w_next = S_IDLE;
            endcase
        end
    end

    // Output decode: next values of the registered status and pulse outputs.
    always_comb begin
        w_stimulus_d    = 1'b0;
        w_busy_d        = 1'b0;
        w_rt_valid_d    = 1'b0;
        w_false_start_d = 1'b0;
        w_done_d        = 1'b0;
        w_stimulus_d    = (w_next == S_REACT);
        w_busy_d        = (w_next != S_IDLE);
        w_rt_valid_d    = (r_state == S_RECORD) && (w_next != S_IDLE);
        w_false_start_d = (r_state == S_DELAY) && (w_next == S_FAULT);
        w_done_d        = (w_next == S_DONE);
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stimulus    <= 1'b0;
            r_busy        <= 1'b0;
            r_rt_valid    <= 1'b0;
            r_false_start <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_stimulus    <= w_stimulus_d;
            r_busy        <= w_busy_d;
            r_rt_valid    <= w_rt_valid_d;
            r_false_start <= w_false_start_d;
            r_done        <= w_done_d;
        end
    end

    // Free-running LFSR and react edge history; react_q resets high so a held
    // button never looks like a fresh press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr    <= 16'hACE1;
            r_react_q <= 1'b1;
        end else begin
            r_lfsr    <= {w_lfsr_fb, r_lfsr[15:1]};
            r_react_q <= bus.i_react;
        end
    end

    // Millisecond prescaler: counts TICK_DIV-1 down to 0, ticking at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_presc <= PW'(TICK_DIV - 1);
        end else if (w_presc_clr || w_tick) begin
            r_presc <= PW'(TICK_DIV - 1);
        end else begin
            r_presc <= r_presc - {{(PW-1){1'b0}}, 1'b1};
        end
    end

    // Shared down-counter: pre-stimulus delay in DELAY, hold time in FAULT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_delay <= 16'd0;
        end else begin
            case (r_state)
                S_ARM:   r_delay <= 16'(MIN_DELAY_MS) + {5'd0, r_lfsr[10:0]};
                S_DELAY: begin
                    if (w_next == S_FAULT)                 r_delay <= 16'(FAULT_MS);
                    else if (w_tick && (r_delay != 16'd0)) r_delay <= r_delay - 16'd1;
                    else                                   r_delay <= r_delay;
                end
                S_FAULT: begin
                    if (w_tick && (r_delay != 16'd0)) r_delay <= r_delay - 16'd1;
                    else                              r_delay <= r_delay;
                end
                default: r_delay <= r_delay;
            endcase
        end
    end

    // Reaction counter (saturating at 999) and capture of its value on the press.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms     <= 10'd0;
            r_rt_cap <= 10'd0;
        end else begin
            if ((r_state == S_DELAY) && (w_next == S_REACT)) begin
                r_ms <= 10'd0;
            end else if ((r_state == S_REACT) && w_tick && (r_ms != MS_MAX)) begin
                r_ms <= r_ms + 10'd1;
            end else begin
                r_ms <= r_ms;
            end
            if ((r_state == S_REACT) && (w_next == S_RECORD)) begin
                r_rt_cap <= r_ms;
            end else begin
                r_rt_cap <= r_rt_cap;
            end
        end
    end

    // Session scoring: round index, running sum, best, last result, average.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_round <= 3'd0;
            r_sum   <= 13'd0;
            r_best  <= MS_MAX;
            r_avg   <= 10'd0;
            r_rt_ms <= 10'd0;
        end else begin
            if ((r_state == S_IDLE) && (w_next == S_ARM)) begin
                r_round <= 3'd0;
                r_sum   <= 13'd0;
                r_best  <= MS_MAX;
            end else if ((r_state == S_RECORD) && (w_next != S_IDLE)) begin
                r_sum   <= r_sum + {3'd0, r_rt_cap};
                r_best  <= (r_rt_cap < r_best) ? r_rt_cap : r_best;
                r_rt_ms <= r_rt_cap;
                if (w_next == S_ARM) begin
                    r_round <= r_round + 3'd1;
                end else begin
                    r_round <= r_round;
                end
            end else if ((r_state == S_DONE) && !bus.i_abort) begin
                r_avg <= 10'(r_sum >> LOG2_R);
            end else begin
                r_round <= r_round;
            end
        end
    end

    assign bus.o_stimulus    = r_stimulus;
    assign bus.o_busy        = r_busy;
    assign bus.o_round_idx   = r_round;
    assign bus.o_rt_ms       = r_rt_ms;
    assign bus.o_rt_valid    = r_rt_valid;
    assign bus.o_false_start = r_false_start;
    assign bus.o_best_ms     = r_best;
    assign bus.o_avg_ms      = r_avg;
    assign bus.o_done        = r_done;
    assign bus.o_state_code  = r_state;
endmodule

// File: tb/tb_reaction_round_controller.sv
// tb_reaction_round_controller
// Directed bench: TICK_DIV=4, ROUNDS=2, MIN_DELAY_MS=2, FAULT_MS=3.
// Follows REACT_TIMEOUT_EN the same way the design does.
module tb_reaction_round_controller;
    localparam int TD    = 4;
    localparam int MIN_D = 2;
    localparam int FLT   = 3;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    reaction_round_controller_if ifc();

    reaction_round_controller #(
        .CLK_HZ(TD * 1000), .ROUNDS(2), .MIN_DELAY_MS(MIN_D), .FAULT_MS(FLT)
    ) dut (
        .clk(clk), .reset(reset), .bus(ifc)
    );

    int n_total = 0;
    int n_bad   = 0;
    int done_cnt = 0;
    int rv_cnt   = 0;
    int fs_cnt   = 0;
    logic [15:0] m_lfsr;

    // Reference LFSR: taps 16,14,13,11, seed ACE1, one step per clock.
    always @(posedge clk) begin
        if (reset) m_lfsr <= 16'hACE1;
        else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    // Pulse counters.
    always @(negedge clk) begin
        if (ifc.o_done === 1'b1)        done_cnt++;
        if (ifc.o_rt_valid === 1'b1)    rv_cnt++;
        if (ifc.o_false_start === 1'b1) fs_cnt++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] code, input int budget, input string tag);
        int n = 0;
        while (ifc.o_state_code !== code && n < budget) begin
            step();
            n++;
        end
        check_val(tag, 32'(ifc.o_state_code), 32'(code));
    endtask

    task automatic start_session();
        ifc.i_start = 1'b1;
        step();
        ifc.i_start = 1'b0;
    endtask

    // Waits through ARM and DELAY; checks DELAY length against the reference LFSR.
    task automatic wait_stim(input string tag);
        int n = 0;
        int len;
        int dly;
        wait_state(3'd1, 20, {tag, "_arm"});
        len = MIN_D + int'(m_lfsr[10:0]);
        while (ifc.o_stimulus !== 1'b1 && n < TD * len + 20) begin
            step();
            n++;
        end
        dly = n - 1;
        check_val({tag, "_delay_cycles"},
                  32'((dly >= TD * len - 1 && dly <= TD * len + 1) ? TD * len : dly),
                  32'(TD * len));
        check_val({tag, "_stim"}, 32'(ifc.o_stimulus), 32'd1);
    endtask

    // Presses react once the ms counter reads `ticks`; checks the recorded value.
    task automatic react_after(input int ticks, input string tag);
        repeat (TD * ticks) step();
        ifc.i_react = 1'b1;
        step();
        check_val({tag, "_record_state"}, 32'(ifc.o_state_code), 32'd4);
        check_val({tag, "_stim_off"}, 32'(ifc.o_stimulus), 32'd0);
        step();
        check_val({tag, "_rt_valid"}, 32'(ifc.o_rt_valid), 32'd1);
        check_val({tag, "_rt_ms"}, 32'(ifc.o_rt_ms), 32'(ticks));
        ifc.i_react = 1'b0;
    endtask

    initial begin
        int d0;
        int r0;
        int f0;
        int n;
        ifc.i_start = 1'b0;
        ifc.i_react = 1'b0;
        ifc.i_abort = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (20) step();

        // Reset state.
        check_val("rst_stimulus", 32'(ifc.o_stimulus), 32'd0);
        check_val("rst_busy", 32'(ifc.o_busy), 32'd0);
        check_val("rst_round", 32'(ifc.o_round_idx), 32'd0);
        check_val("rst_rt_ms", 32'(ifc.o_rt_ms), 32'd0);
        check_val("rst_best", 32'(ifc.o_best_ms), 32'd999);
        check_val("rst_avg", 32'(ifc.o_avg_ms), 32'd0);
        check_val("rst_pulses", 32'(done_cnt + rv_cnt + fs_cnt), 32'd0);
        check_val("rst_state", 32'(ifc.o_state_code), 32'd0);

        // Abort in REACT.
        start_session();
        check_val("ab_busy", 32'(ifc.o_busy), 32'd1);
        wait_stim("ab");
        repeat (5) step();
        check_val("ab_react_state", 32'(ifc.o_state_code), 32'd3);
        ifc.i_abort = 1'b1;
        step();
        ifc.i_abort = 1'b0;
        check_val("ab_state", 32'(ifc.o_state_code), 32'd0);
        check_val("ab_stim", 32'(ifc.o_stimulus), 32'd0);
        check_val("ab_busy_off", 32'(ifc.o_busy), 32'd0);
        check_val("ab_best", 32'(ifc.o_best_ms), 32'd999);
        check_val("ab_avg", 32'(ifc.o_avg_ms), 32'd0);
        repeat (3) step();
        check_val("ab_no_pulses", 32'(done_cnt + rv_cnt + fs_cnt), 32'd0);

        // Two clean rounds: 10 ms then 30 ms.
        d0 = done_cnt;
        start_session();
        wait_stim("m0");
        check_val("m0_round", 32'(ifc.o_round_idx), 32'd0);
        react_after(10, "m0");
        check_val("m0_round_next", 32'(ifc.o_round_idx), 32'd1);
        wait_stim("m1");
        react_after(30, "m1");
        check_val("m_done_pulse", 32'(ifc.o_done), 32'd1);
        check_val("m_best", 32'(ifc.o_best_ms), 32'd10);
        step();
        check_val("m_avg", 32'(ifc.o_avg_ms), 32'd20);
        check_val("m_idle", 32'(ifc.o_state_code), 32'd0);
        repeat (3) step();
        check_val("m_done_count", 32'(done_cnt - d0), 32'd1);
        check_val("m_hold_rt", 32'(ifc.o_rt_ms), 32'd30);

        // False start, then rounds of 7 ms and 13 ms.
        f0 = fs_cnt;
        start_session();
        wait_state(3'd2, 10, "fs_delay");
        repeat (3) step();
        ifc.i_react = 1'b1;
        step();
        check_val("fs_pulse", 32'(ifc.o_false_start), 32'd1);
        check_val("fs_state", 32'(ifc.o_state_code), 32'd5);
        ifc.i_react = 1'b0;
        n = 0;
        while (ifc.o_state_code === 3'd5 && n < 100) begin
            step();
            n++;
        end
        check_val("fs_fault_cycles",
                  32'((n >= TD * FLT - 1 && n <= TD * FLT + 1) ? TD * FLT : n), 32'(TD * FLT));
        check_val("fs_round", 32'(ifc.o_round_idx), 32'd0);
        wait_stim("fs0");
        react_after(7, "fs0");
        wait_stim("fs1");
        react_after(13, "fs1");
        check_val("fs_best", 32'(ifc.o_best_ms), 32'd7);
        step();
        check_val("fs_avg", 32'(ifc.o_avg_ms), 32'd10);
        check_val("fs_count", 32'(fs_cnt - f0), 32'd1);

        // Button held across start and stimulus.
        f0 = fs_cnt;
        r0 = rv_cnt;
        ifc.i_react = 1'b1;
        repeat (2) step();
        start_session();
        wait_stim("hold");
        repeat (TD * 8) step();
        check_val("hold_state", 32'(ifc.o_state_code), 32'd3);
        check_val("hold_no_fs", 32'(fs_cnt - f0), 32'd0);
        check_val("hold_no_rv", 32'(rv_cnt - r0), 32'd0);
        ifc.i_react = 1'b0;
        step();
        ifc.i_react = 1'b1;
        step();
        step();
        check_val("hold_rt_valid", 32'(ifc.o_rt_valid), 32'd1);
        check_val("hold_rt_ms", 32'(ifc.o_rt_ms), 32'd8);
        ifc.i_react = 1'b0;
        ifc.i_abort = 1'b1;
        step();
        ifc.i_abort = 1'b0;
        check_val("hold_abort_idle", 32'(ifc.o_state_code), 32'd0);

        // No press at all.
        r0 = rv_cnt;
        start_session();
        wait_stim("to");
`ifdef REACT_TIMEOUT_EN
        n = 0;
        while (rv_cnt == r0 && n < TD * 1000 + 20) begin
            step();
            n++;
        end
        check_val("to_time",
                  32'((n >= TD * 999 && n <= TD * 999 + 4) ? TD * 999 : n), 32'(TD * 999));
        check_val("to_rt_ms", 32'(ifc.o_rt_ms), 32'd999);
`else
        repeat (TD * 2000 + 4) step();
        check_val("to_wait_state", 32'(ifc.o_state_code), 32'd3);
        check_val("to_no_rv", 32'(rv_cnt - r0), 32'd0);
        ifc.i_react = 1'b1;
        step();
        step();
        check_val("to_late_rv", 32'(ifc.o_rt_valid), 32'd1);
        check_val("to_late_rt", 32'(ifc.o_rt_ms), 32'd999);
        ifc.i_react = 1'b0;
`endif
        ifc.i_abort = 1'b1;
        step();
        ifc.i_abort = 1'b0;
        check_val("to_abort_idle", 32'(ifc.o_state_code), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
